// File: rtl/dapuf_eval_if.sv
// Handshake and DAPUF-side signal bundle for the DAPUF evaluation controller.
// The master side is the environment (challenge source, result sink, DAPUF core model).
interface dapuf_eval_if #(
  parameter int CHAL_W    = 40,
  parameter int NUM_EVALS = 15
);
  localparam int ONES_W = $clog2(NUM_EVALS + 1);

  logic [CHAL_W-1:0] chal_in;
  logic              chal_valid;
  logic              chal_ready;
  logic [CHAL_W-1:0] challenge;
  logic              exciteL;
  logic              exciteR;
  logic              puf_resp;
  logic              resp_out;
  logic [ONES_W-1:0] resp_ones;
  logic              resp_stable;
  logic              resp_valid;
  logic              resp_ready;
  logic              busy;

  modport master (
    output chal_in, chal_valid, resp_ready, puf_resp,
    input  chal_ready, challenge, exciteL, exciteR,
           resp_out, resp_ones, resp_stable, resp_valid, busy
  );

  modport slave (
    input  chal_in, chal_valid, resp_ready, puf_resp,
    output chal_ready, challenge, exciteL, exciteR,
           resp_out, resp_ones, resp_stable, resp_valid, busy
  );
endinterface

// File: rtl/dapuf_eval_ctrl.sv
// DAPUF evaluation sequencer: settles a challenge, fires excite NUM_EVALS times,
// counts synchronised responses and returns a majority-voted result.
module dapuf_eval_ctrl #(
  parameter int CHAL_W      = 40,
  parameter int CHAL_SETTLE = 8,
  parameter int RESP_SETTLE = 16,
  parameter int RELAX       = 8,
  parameter int NUM_EVALS   = 15
) (
  input  logic        clk,
  input  logic        rst,
  dapuf_eval_if.slave bus
);
  localparam int ONES_W  = $clog2(NUM_EVALS + 1);
  localparam int T_MAX_A = (CHAL_SETTLE > RESP_SETTLE) ? CHAL_SETTLE : RESP_SETTLE;
  localparam int T_MAX   = (T_MAX_A > RELAX) ? T_MAX_A : RELAX;
  localparam int TIMER_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  localparam logic [TIMER_W-1:0] T_CHAL  = TIMER_W'(CHAL_SETTLE - 1);
  localparam logic [TIMER_W-1:0] T_RESP  = TIMER_W'(RESP_SETTLE - 1);
  localparam logic [TIMER_W-1:0] T_RELAX = TIMER_W'(RELAX - 1);
  localparam logic [ONES_W-1:0]  N_EVALS = ONES_W'(NUM_EVALS);
  localparam logic [ONES_W-1:0]  N_HALF  = ONES_W'(NUM_EVALS / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_SAMPLE,
    S_RELAX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [ONES_W-1:0]  evals_q, evals_d;
  logic [CHAL_W-1:0]  challenge_q, challenge_d;
  logic               excite_q, excite_d;
  logic               res_out_q, res_out_d;
  logic [ONES_W-1:0]  res_ones_q, res_ones_d;
  logic               res_stable_q, res_stable_d;
  logic [1:0]         sync_q;
  logic               sync_resp;
  logic               chal_ready_w;
  logic               timer_zero;

  assign sync_resp    = sync_q[1];
  assign chal_ready_w = (state_q == S_IDLE) && !rst;
  assign timer_zero   = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ones_q       <= '0;
      evals_q      <= '0;
      challenge_q  <= '0;
      excite_q     <= 1'b0;
      res_out_q    <= 1'b0;
      res_ones_q   <= '0;
      res_stable_q <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ones_q       <= ones_d;
      evals_q      <= evals_d;
      challenge_q  <= challenge_d;
      excite_q     <= excite_d;
      res_out_q    <= res_out_d;
      res_ones_q   <= res_ones_d;
      res_stable_q <= res_stable_d;
      sync_q       <= {sync_q[0], bus.puf_resp};
    end
  end

  // Excite is registered from the next state so it is high exactly in FIRE and SAMPLE.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ones_d       = ones_q;
    evals_d      = evals_q;
    challenge_d  = challenge_q;
    res_out_d    = res_out_q;
    res_ones_d   = res_ones_q;
    res_stable_d = res_stable_q;

    case (state_q)
      S_IDLE: begin
        if (bus.chal_valid && chal_ready_w) begin
          state_d     = S_SETUP;
          challenge_d = bus.chal_in;
          ones_d      = '0;
          evals_d     = '0;
          timer_d     = T_CHAL;
        end
      end
      S_SETUP: begin
        if (timer_zero) begin
          state_d = S_FIRE;
          timer_d = T_RESP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_FIRE: begin
        if (timer_zero) begin
          state_d = S_SAMPLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        ones_d  = (ones_q == N_EVALS) ? ones_q : ones_q + ONES_W'(sync_resp);
        evals_d = evals_q + 1'b1;
        state_d = S_RELAX;
        timer_d = T_RELAX;
      end
      S_RELAX: begin
        if (!timer_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (evals_q == N_EVALS) begin
          state_d      = S_DONE;
          res_out_d    = (ones_q > N_HALF);
          res_ones_d   = ones_q;
          res_stable_d = (ones_q == '0) || (ones_q == N_EVALS);
        end else begin
          state_d = S_FIRE;
          timer_d = T_RESP;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    excite_d = (state_d == S_FIRE) || (state_d == S_SAMPLE);
  end

  assign bus.chal_ready  = chal_ready_w;
  assign bus.challenge   = challenge_q;
  assign bus.exciteL     = excite_q;
  assign bus.exciteR     = excite_q;
  assign bus.resp_out    = res_out_q;
  assign bus.resp_ones   = res_ones_q;
  assign bus.resp_stable = res_stable_q;
  assign bus.resp_valid  = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);

  ones_no_overflow: assert property (@(posedge clk) disable iff (rst) ones_q <= N_EVALS);
endmodule

// File: tb/tb_dapuf_eval_ctrl.sv
// Directed-plus-random bench for dapuf_eval_ctrl; results are predicted from the
// per-evaluation response bits with a popcount/majority model.
module tb_dapuf_eval_ctrl;
  localparam int CHAL_W      = 40;
  localparam int CHAL_SETTLE = 2;
  localparam int RESP_SETTLE = 3;
  localparam int RELAX       = 2;
  localparam int NUM_EVALS   = 3;
  localparam int LATENCY     = CHAL_SETTLE + NUM_EVALS * (RESP_SETTLE + 1 + RELAX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  dapuf_eval_if #(.CHAL_W(CHAL_W), .NUM_EVALS(NUM_EVALS)) bus ();

  dapuf_eval_ctrl #(
    .CHAL_W(CHAL_W), .CHAL_SETTLE(CHAL_SETTLE), .RESP_SETTLE(RESP_SETTLE),
    .RELAX(RELAX), .NUM_EVALS(NUM_EVALS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one challenge; bits[k] is the DAPUF response presented during evaluation k.
  task automatic applyStimulus(input string name, input logic [CHAL_W-1:0] chal,
                               input logic [NUM_EVALS-1:0] bits, input int hold,
                               input int abort_at);
    int edges, k, hi_run, lo_run, rises, bad_hi, bad_lo, bad_pair, bad_chal, bad_hold;
    int exp_ones;
    logic prev_ex, aborted;

    exp_ones = $countones(bits);
    edges = 0;
    while (!bus.chal_ready && edges < 100) begin
      tick();
      edges++;
    end
    checkOutput({name, "_ready_before_accept"}, 64'(bus.chal_ready), 64'd1);
    checkOutput({name, "_idle_no_excite"}, 64'(bus.exciteL | bus.exciteR), 64'd0);

    bus.chal_in    = chal;
    bus.chal_valid = 1'b1;
    tick();
    checkOutput({name, "_challenge_latched"}, 64'(bus.challenge), 64'(chal));

    edges = 0; k = 0; hi_run = 0; lo_run = 0; rises = 0;
    bad_hi = 0; bad_lo = 0; bad_pair = 0; bad_chal = 0; bad_hold = 0;
    prev_ex = 1'b0; aborted = 1'b0;
    while (!bus.resp_valid && edges < 200) begin
      bus.chal_valid = 1'($urandom_range(0, 1));
      bus.chal_in    = CHAL_W'({$urandom(), $urandom()});
      bus.resp_ready = 1'($urandom_range(0, 1));
      if (bus.exciteL !== bus.exciteR) bad_pair++;
      if (bus.challenge !== chal) bad_chal++;
      if (bus.exciteL && !prev_ex) begin
        if (rises > 0 && lo_run != RELAX) bad_lo++;
        rises++;
        hi_run = 0;
        bus.puf_resp = (k < NUM_EVALS) ? bits[k] : 1'b0;
        k++;
      end
      if (!bus.exciteL && prev_ex) begin
        if (hi_run != RESP_SETTLE + 1) bad_hi++;
        lo_run = 0;
      end
      if (bus.exciteL) hi_run++;
      else lo_run++;
      prev_ex = bus.exciteL;
      if (abort_at > 0 && rises == abort_at) begin
        rst = 1'b1;
        tick();
        checkOutput({name, "_abort_excite"}, 64'(bus.exciteL | bus.exciteR), 64'd0);
        checkOutput({name, "_abort_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({name, "_abort_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        checkOutput({name, "_abort_challenge"}, 64'(bus.challenge), 64'd0);
        checkOutput({name, "_abort_ready_in_reset"}, 64'(bus.chal_ready), 64'd0);
        bus.chal_valid = 1'b0;
        bus.puf_resp   = 1'b0;
        rst = 1'b0;
        tick();
        checkOutput({name, "_abort_ready_after"}, 64'(bus.chal_ready), 64'd1);
        aborted = 1'b1;
        break;
      end
      tick();
      edges++;
    end

    if (!aborted) begin
      checkOutput({name, "_latency"}, 64'(edges), 64'(LATENCY));
      checkOutput({name, "_resp_ones"}, 64'(bus.resp_ones), 64'(exp_ones));
      checkOutput({name, "_resp_out"}, 64'(bus.resp_out), 64'(exp_ones * 2 > NUM_EVALS));
      checkOutput({name, "_resp_stable"}, 64'(bus.resp_stable),
                  64'(exp_ones == 0 || exp_ones == NUM_EVALS));
      checkOutput({name, "_excite_rises"}, 64'(rises), 64'(NUM_EVALS));
      checkOutput({name, "_excite_pair"}, 64'(bad_pair), 64'd0);
      checkOutput({name, "_excite_high_len"}, 64'(bad_hi), 64'd0);
      checkOutput({name, "_excite_low_len"}, 64'(bad_lo), 64'd0);
      checkOutput({name, "_challenge_held"}, 64'(bad_chal), 64'd0);
      checkOutput({name, "_ready_low_in_done"}, 64'(bus.chal_ready), 64'd0);

      for (int i = 0; i < hold; i++) begin
        bus.resp_ready = 1'b0;
        bus.chal_valid = 1'b1;
        bus.chal_in    = CHAL_W'({$urandom(), $urandom()});
        tick();
        if (bus.resp_valid !== 1'b1 || bus.chal_ready !== 1'b0 || bus.busy !== 1'b1 ||
            bus.resp_ones !== 2'(exp_ones) || bus.challenge !== chal ||
            bus.resp_out !== (exp_ones * 2 > NUM_EVALS))
          bad_hold++;
      end
      if (hold > 0) checkOutput({name, "_backpressure_hold"}, 64'(bad_hold), 64'd0);

      bus.chal_valid = 1'b0;
      bus.resp_ready = 1'b1;
      tick();
      checkOutput({name, "_resp_valid_cleared"}, 64'(bus.resp_valid), 64'd0);
      checkOutput({name, "_ready_after_done"}, 64'(bus.chal_ready), 64'd1);
      checkOutput({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
      bus.resp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [CHAL_W-1:0]    chal;
    logic [NUM_EVALS-1:0] bits;

    bus.chal_in    = '0;
    bus.chal_valid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.puf_resp   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_challenge", 64'(bus.challenge), 64'd0);
    checkOutput("reset_excite", 64'(bus.exciteL | bus.exciteR), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("reset_resp_ones", 64'(bus.resp_ones), 64'd0);
    checkOutput("reset_chal_ready", 64'(bus.chal_ready), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] all-ones response");
    applyStimulus("all_ones", 40'hA5A5A5A5A5, 3'b111, 0, 0);

    $display("[TB] mixed responses");
    applyStimulus("mix_101", CHAL_W'({$urandom(), $urandom()}), 3'b101, 0, 0);
    applyStimulus("mix_001", CHAL_W'({$urandom(), $urandom()}), 3'b100, 0, 0);

    $display("[TB] backpressure in DONE");
    applyStimulus("backpressure", CHAL_W'({$urandom(), $urandom()}), 3'b010, 10, 0);

    $display("[TB] reset during second FIRE");
    applyStimulus("abort", 40'h123456789A, 3'b111, 0, 2);
    applyStimulus("after_abort", 40'h0F0F0F0F0F, 3'b111, 0, 0);

    $display("[TB] back-to-back random challenges");
    for (int n = 0; n < 6; n++) begin
      chal = CHAL_W'({$urandom(), $urandom()});
      bits = NUM_EVALS'($urandom());
      applyStimulus("random", chal, bits, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
